// File: rtl/tick_counter.sv
// tick_counter: modulo up/down counter driven by clkscaler strobes with reference-edge snapshot
module tick_counter #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] MAX_COUNT = WIDTH'(9999)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_clk,
   input  logic             ref_clk,
   input  logic             enable,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             clear_flags,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] snapshot,
   output logic             snapshot_valid,
   output logic             overflow,
   output logic             underflow
);
   logic             inc_prev_q, ref_prev_q;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] snap_q, snap_d;
   logic             snap_vld_q, snap_vld_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             tick, refedge;
   assign tick    = inc_clk & ~inc_prev_q;
   assign refedge = ref_clk & ~ref_prev_q;
   // next count and flags: load beats ticks; a wrap sets its flag even while clear_flags is high
   always_comb begin
      count_d    = count_q;
      ovf_d      = clear_flags ? 1'b0 : ovf_q;
      unf_d      = clear_flags ? 1'b0 : unf_q;
      snap_d     = refedge ? count_q : snap_q;
      snap_vld_d = refedge;
      if (load) begin
         count_d = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
      end else if (tick && enable && up_down) begin
         count_d = (count_q == MAX_COUNT) ? '0 : count_q + WIDTH'(1);
         ovf_d   = (count_q == MAX_COUNT) ? 1'b1 : ovf_d;
      end else if (tick && enable) begin
         count_d = (count_q == '0) ? MAX_COUNT : count_q - WIDTH'(1);
         unf_d   = (count_q == '0) ? 1'b1 : unf_d;
      end
   end
   // state registers; strobe history resets high so a strobe held through reset is not a tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inc_prev_q <= 1'b1;
         ref_prev_q <= 1'b1;
         count_q    <= '0;
         snap_q     <= '0;
         snap_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         inc_prev_q <= inc_clk;
         ref_prev_q <= ref_clk;
         count_q    <= count_d;
         snap_q     <= snap_d;
         snap_vld_q <= snap_vld_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end
   assign count          = count_q;
   assign snapshot       = snap_q;
   assign snapshot_valid = snap_vld_q;
   assign overflow       = ovf_q;
   assign underflow      = unf_q;
endmodule

// File: tb/tb_tick_counter.sv
// tb_tick_counter: directed checks of tick_counter counting, wrap flags, load clamp and snapshot
module tb_tick_counter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inc_clk = 1'b1;
   logic        ref_clk = 1'b1;
   logic        enable = 1'b0;
   logic        up_down = 1'b1;
   logic        load = 1'b0;
   logic [15:0] load_value = '0;
   logic        clear_flags = 1'b0;
   logic [15:0] count, snapshot;
   logic        snapshot_valid, overflow, underflow;
   int          n_chk = 0;
   int          n_pass = 0;
   int          pulses;

   tick_counter dut (
      .clk(clk), .reset(reset), .inc_clk(inc_clk), .ref_clk(ref_clk),
      .enable(enable), .up_down(up_down), .load(load), .load_value(load_value),
      .clear_flags(clear_flags), .count(count), .snapshot(snapshot),
      .snapshot_valid(snapshot_valid), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int w);
      inc_clk = 1'b1;
      repeat (w) step();
      inc_clk = 1'b0;
      step();
   endtask

   task automatic do_load(input logic [15:0] v);
      load = 1'b1;
      load_value = v;
      step();
      load = 1'b0;
   endtask

   initial begin
      repeat (2) step();
      chk("rst_count", count, 0);
      chk("rst_snap", snapshot, 0);
      chk("rst_valid", snapshot_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_unf", underflow, 0);
      ref_clk = 1'b0;
      enable = 1'b1;
      reset = 1'b0;
      repeat (3) step();
      chk("held_through_reset", count, 0);
      inc_clk = 1'b0;
      step();
      for (int i = 1; i <= 5; i++) begin
         pulse(3);
         chk($sformatf("up_pulse%0d", i), count, i);
      end
      chk("up_ovf", overflow, 0);
      do_load(16'd9998);
      chk("load_9998", count, 9998);
      pulse(1);
      chk("up_9999", count, 9999);
      chk("ovf_before_wrap", overflow, 0);
      pulse(1);
      chk("wrap_0", count, 0);
      chk("ovf_set", overflow, 1);
      pulse(1);
      chk("after_wrap_1", count, 1);
      chk("ovf_sticky", overflow, 1);
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      chk("ovf_cleared", overflow, 0);
      do_load(16'd9999);
      clear_flags = 1'b1;
      inc_clk = 1'b1;
      step();
      clear_flags = 1'b0;
      inc_clk = 1'b0;
      chk("set_wins_count", count, 0);
      chk("set_wins_ovf", overflow, 1);
      step();
      do_load(16'd0);
      up_down = 1'b0;
      pulse(1);
      chk("down_wrap", count, 9999);
      chk("unf_set", underflow, 1);
      chk("ovf_keep", overflow, 1);
      pulse(2);
      chk("down_9998", count, 9998);
      do_load(16'd20000);
      chk("load_clamp", count, 9999);
      load = 1'b1;
      load_value = 16'd5;
      inc_clk = 1'b1;
      step();
      load = 1'b0;
      inc_clk = 1'b0;
      chk("load_beats_tick", count, 5);
      step();
      do_load(16'd7);
      up_down = 1'b1;
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      chk("flags_clear_ovf", overflow, 0);
      chk("flags_clear_unf", underflow, 0);
      inc_clk = 1'b1;
      ref_clk = 1'b1;
      step();
      chk("snap_old", snapshot, 7);
      chk("snap_count", count, 8);
      chk("snap_valid_hi", snapshot_valid, 1);
      inc_clk = 1'b0;
      pulses = 0;
      repeat (10) begin
         step();
         pulses += int'(snapshot_valid);
      end
      chk("snap_no_repeat", pulses, 0);
      ref_clk = 1'b0;
      step();
      enable = 1'b0;
      for (int i = 0; i < 4; i++) pulse(2);
      chk("disabled_hold", count, 8);
      inc_clk = 1'b1;
      step();
      enable = 1'b1;
      repeat (2) step();
      chk("enable_mid_high", count, 8);
      inc_clk = 1'b0;
      step();
      pulse(1);
      chk("enable_next_edge", count, 9);
      enable = 1'b0;
      ref_clk = 1'b1;
      step();
      ref_clk = 1'b0;
      chk("snap_while_disabled", snapshot, 9);
      enable = 1'b1;
      step();
      do_load(16'd42);
      chk("load_42", count, 42);
      ref_clk = 1'b1;
      step();
      ref_clk = 1'b0;
      chk("snap_42", snapshot, 42);
      #3;
      reset = 1'b1;
      #1;
      chk("async_count", count, 0);
      chk("async_snap", snapshot, 0);
      chk("async_valid", snapshot_valid, 0);
      step();
      reset = 1'b0;
      step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
